// File: rtl/time_entry_loader.sv
// Keypad entry front end for the microwave countdown chain: buffers MM:SS digits,
// validates the entry, pulses the parallel load and gates the 1 Hz count enable.
module time_entry_loader #(
  parameter int unsigned MAX_SEC_TENS = 5,
  parameter int unsigned LOAD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       start,
  input  logic       clear,
  input  logic       tick,
  input  logic       timer_done,
  output logic [3:0] d_sec0,
  output logic [3:0] d_sec1,
  output logic [3:0] d_min0,
  output logic [3:0] d_min1,
  output logic       load_n,
  output logic       count_en,
  output logic       busy,
  output logic       done,
  output logic       entry_err
);

  localparam logic [3:0] MaxSecTens = 4'(MAX_SEC_TENS);
  localparam logic [1:0] LastLoad   = 2'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StLoad,
    StRun,
    StPaused,
    StDone
  } state_e;

  state_e           state_q, state_d;
  // Digit buffer, index 0 = seconds-ones .. index 3 = minutes-tens.
  logic [3:0][3:0]  dig_q, dig_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       lcnt_q, lcnt_d;
  logic             armed_q, armed_d;
  logic             load_n_q, load_n_d;
  logic             count_en_q, count_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             start_ok;

  assign start_ok = (dig_q != '0) && (dig_q[1] <= MaxSecTens);

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    lcnt_d     = lcnt_q;
    armed_d    = armed_q;
    load_n_d   = 1'b1;
    count_en_d = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle, StEntry: begin
        if (clear) begin
          state_d = StIdle;
          dig_d   = '0;
          cnt_d   = '0;
        end else if (start) begin
          if (state_q == StIdle || !start_ok) begin
            err_d = 1'b1;
          end else begin
            state_d  = StLoad;
            load_n_d = 1'b0;
            lcnt_d   = '0;
          end
        end else if (key_valid) begin
          if (key > 4'd9 || cnt_q == 3'd4) begin
            err_d = 1'b1;
          end else begin
            dig_d   = {dig_q[2:0], key};
            cnt_d   = cnt_q + 3'd1;
            state_d = StEntry;
          end
        end
      end

      StLoad: begin
        if (clear) begin
          state_d = StIdle;
          dig_d   = '0;
          cnt_d   = '0;
        end else if (lcnt_q == LastLoad) begin
          state_d = StRun;
          armed_d = 1'b0;
        end else begin
          lcnt_d   = lcnt_q + 2'd1;
          load_n_d = 1'b0;
        end
      end

      StRun: begin
        if (clear) begin
          state_d = StPaused;
        end else if (armed_q && timer_done) begin
          state_d = StDone;
        end else begin
          // timer_done may still reflect the pre-load count in the first RUN cycle.
          armed_d    = 1'b1;
          count_en_d = tick;
        end
      end

      StPaused: begin
        if (clear) begin
          state_d = StIdle;
          dig_d   = '0;
          cnt_d   = '0;
        end else if (start) begin
          state_d = StRun;
        end
      end

      StDone: begin
        if (key_valid || start || clear) begin
          state_d = StIdle;
          dig_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        dig_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_d = state_d inside {StLoad, StRun, StPaused};
  assign done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      dig_q      <= '0;
      cnt_q      <= '0;
      lcnt_q     <= '0;
      armed_q    <= 1'b0;
      load_n_q   <= 1'b1;
      count_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      lcnt_q     <= lcnt_d;
      armed_q    <= armed_d;
      load_n_q   <= load_n_d;
      count_en_q <= count_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign d_sec0    = dig_q[0];
  assign d_sec1    = dig_q[1];
  assign d_min0    = dig_q[2];
  assign d_min1    = dig_q[3];
  assign load_n    = load_n_q;
  assign count_en  = count_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign entry_err = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Self-checking bench for time_entry_loader: a behavioural model predicts the
// outputs of every cycle into a queue that is popped after each clock edge.
module tb_time_entry_loader;

  localparam int LC = 1;
  localparam int MIdle = 0, MEntry = 1, MLoad = 2, MRun = 3, MPaused = 4, MDone = 5;

  logic       clk = 1'b0;
  logic       clrn;
  logic       key_valid, start, clear, tick, timer_done;
  logic [3:0] key;
  logic [3:0] d_sec0, d_sec1, d_min0, d_min1;
  logic       load_n, count_en, busy, done, entry_err;

  time_entry_loader #(
    .MAX_SEC_TENS(5),
    .LOAD_CYCLES (LC)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key       (key),
    .start     (start),
    .clear     (clear),
    .tick      (tick),
    .timer_done(timer_done),
    .d_sec0    (d_sec0),
    .d_sec1    (d_sec1),
    .d_min0    (d_min0),
    .d_min1    (d_min1),
    .load_n    (load_n),
    .count_en  (count_en),
    .busy      (busy),
    .done      (done),
    .entry_err (entry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic        ln, cen, bsy, dn, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  int          m_st;
  logic [15:0] m_dig;
  int          m_cnt, m_lcnt;
  logic        m_armed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = MIdle; m_dig = '0; m_cnt = 0; m_lcnt = 0; m_armed = 1'b0;
  endtask

  task automatic model_zero();
    m_st = MIdle; m_dig = '0; m_cnt = 0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] k, input logic st,
                            input logic cl, input logic tk, input logic td, output exp_t e);
    e.ln = 1'b1; e.cen = 1'b0; e.err = 1'b0;
    case (m_st)
      MIdle, MEntry: begin
        if (cl) model_zero();
        else if (st) begin
          if (m_st == MIdle || m_dig == 16'h0 || m_dig[7:4] > 4'd5) e.err = 1'b1;
          else begin m_st = MLoad; m_lcnt = 1; e.ln = 1'b0; end
        end else if (kv) begin
          if (k > 4'd9 || m_cnt == 4) e.err = 1'b1;
          else begin m_dig = {m_dig[11:0], k}; m_cnt++; m_st = MEntry; end
        end
      end
      MLoad: begin
        if (cl) model_zero();
        else if (m_lcnt == LC) begin m_st = MRun; m_armed = 1'b0; end
        else begin m_lcnt++; e.ln = 1'b0; end
      end
      MRun: begin
        if (cl) m_st = MPaused;
        else if (m_armed && td) m_st = MDone;
        else begin m_armed = 1'b1; e.cen = tk; end
      end
      MPaused: begin
        if (cl) model_zero();
        else if (st) m_st = MRun;
      end
      default: if (kv || st || cl) model_zero();
    endcase
    e.dig = m_dig;
    e.bsy = (m_st == MLoad || m_st == MRun || m_st == MPaused);
    e.dn  = (m_st == MDone);
  endtask

  task automatic step(input logic kv, input logic [3:0] k, input logic st,
                      input logic cl, input logic tk);
    exp_t e;
    @(negedge clk);
    key_valid = kv; key = k; start = st; clear = cl; tick = tk;
    model_step(kv, k, st, cl, tk, timer_done, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0; start = 1'b0; clear = 1'b0; tick = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("digits", {d_min1, d_min0, d_sec1, d_sec0}, e.dig);
      check("load_n", load_n, e.ln);
      check("count_en", count_en, e.cen);
      check("busy", busy, e.bsy);
      check("done", done, e.dn);
      check("entry_err", entry_err, e.err);
    end
  endtask

  task automatic key_in(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, {d_min1, d_min0, d_sec1, d_sec0}, 16'h0);
    check({tag, "_load_n"}, load_n, 1'b1);
    check({tag, "_count_en"}, count_en, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_entry_err"}, entry_err, 1'b0);
  endtask

  initial begin
    clrn = 1'b0; key_valid = 1'b0; key = 4'd0; start = 1'b0; clear = 1'b0;
    tick = 1'b0; timer_done = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    clrn = 1'b1;

    // Entry 1,3,0 -> 01:30, load, tick latency.
    key_in(4'd1); key_in(4'd3); key_in(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    key_in(4'd7);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // Pause across three ticks, resume, then completion.
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    timer_done = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    timer_done = 1'b0;
    key_in(4'd4);
    idle(1);

    // Buffer overflow and illegal keys.
    key_in(4'd1); key_in(4'd2); key_in(4'd3); key_in(4'd4);
    key_in(4'd5); key_in(4'd11);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    key_in(4'd11);

    // Rejected starts.
    key_in(4'd0); key_in(4'd7); key_in(4'd5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'd0); key_in(4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    key_in(4'd5); key_in(4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // timer_done already high on entering RUN is ignored for the first cycle.
    key_in(4'd2);
    timer_done = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    timer_done = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Same-cycle priority: clear beats start and key.
    key_in(4'd3);
    step(1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
    key_in(4'd8);
    step(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of LOAD.
    key_in(4'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("load_n_low_in_load", load_n, 1'b0);
    #1;
    clrn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
    idle(1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) timer_done = ~timer_done;
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 11)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
- Upstream stage of the microwave countdown chain. Collects BCD digits from the keypad into a 4-digit MM:SS buffer and validates the entry.
- Drives parallel load data and an active-low load strobe into the mod-10/mod-6 down-counter chain.
- Gates the counter enable from a 1 Hz tick, and handles start, pause/resume, clear and completion.

Parameters:
- MAX_SEC_TENS, 5, highest legal value of the seconds-tens digit; start is rejected above this.
- LOAD_CYCLES, 1, number of clk cycles load_n is held low (1..4).

Ports:
- clk  input  1  system clock, all state on rising edge
- clrn  input  1  asynchronous active-low reset
- key_valid  input  1  single-cycle keypad strobe
- key  input  4  keypad code; 0-9 are digits, 10-15 are illegal
- start  input  1  single-cycle start/resume request
- clear  input  1  single-cycle clear/pause request
- tick  input  1  single-cycle 1 Hz timebase pulse
- timer_done  input  1  level from counter chain: all digits zero
- d_sec0  output  4  seconds-ones load data
- d_sec1  output  4  seconds-tens load data
- d_min0  output  4  minutes-ones load data
- d_min1  output  4  minutes-tens load data
- load_n  output  1  active-low parallel load to counter chain
- count_en  output  1  enable to seconds-ones counter
- busy  output  1  high in LOAD, RUN, PAUSED
- done  output  1  high in DONE state
- entry_err  output  1  one-cycle pulse on a rejected key or start

Behaviour:
- Reset is decided as stated: clrn is asynchronous, active-low; clock is clk.
- Reset values: state IDLE, all digits 0, digit count 0, load_n 1, count_en 0, busy 0, done 0, entry_err 0.
- Same-cycle priority: clear > start > key_valid. Lower-priority events in that cycle are dropped silently, with no error pulse.
- States: IDLE, ENTRY, LOAD, RUN, PAUSED, DONE.
- IDLE/ENTRY, digit key (key <= 9) with digit count < 4:
  - Shift left: d_min1<=d_min0, d_min0<=d_sec1, d_sec1<=d_sec0, d_sec0<=key.
  - Digit count increments; go to ENTRY.
- IDLE/ENTRY, illegal key (key >= 10): digits unchanged, entry_err pulse.
- ENTRY with count = 4, any key: digits unchanged, entry_err pulse.
- ENTRY, start:
  - If all digits are 0, or d_sec1 > MAX_SEC_TENS: stay in ENTRY, entry_err pulse.
  - Otherwise go to LOAD.
- IDLE, start: entry_err pulse, stay in IDLE.
- ENTRY, clear: digits and count go to 0, state IDLE.
- LOAD:
  - load_n is low for exactly LOAD_CYCLES cycles, registered, glitch-free; then go to RUN.
  - Digit outputs are stable throughout LOAD.
  - Keys, start and tick are ignored; clear aborts to IDLE with digits zeroed and load_n returned high on the next edge.
- RUN:
  - count_en = tick, a registered copy giving 1-cycle latency from tick.
  - Keys and start are ignored, no error pulse.
  - clear goes to PAUSED.
  - timer_done is ignored during LOAD and the first RUN cycle. After that, timer_done = 1 goes to DONE and count_en is forced 0 in that same cycle.
- PAUSED:
  - count_en is 0; the counter chain holds its own value and no reload occurs.
  - start returns to RUN; clear goes to IDLE with digits zeroed.
- DONE:
  - done is 1 and count_en is 0.
  - Any key_valid, start or clear goes to IDLE with digits zeroed and count 0. That event is consumed and not treated as a digit.
- busy = state in {LOAD, RUN, PAUSED}; done = (state == DONE). Both are registered.
- Reset asserted mid-operation (any state): all outputs return to their reset values immediately, asynchronously.
- A tick coincident with start in PAUSED is not passed through; counting resumes on the next tick.

Test Plan:
- Reset, then keys 1,3,0 and start → digits 0/1/3/0 (min1/min0/sec1/sec0); load_n low exactly 1 cycle; busy = 1; the next tick gives count_en = 1 for 1 cycle, one cycle later.
- Keys 1,2,3,4 then key 5 → digits stay 1/2/3/4 and entry_err pulses; then key 11 → entry_err pulses, digits unchanged.
- Keys 0,7,5 (sec1 = 7) and start → stays in ENTRY, entry_err pulses, load_n stays 1. Start with all digits zero → entry_err pulses.
- In RUN, clear → PAUSED and count_en stays 0 across 3 ticks; then start → RUN, with no load_n pulse.
- In RUN, timer_done = 1 → done = 1 and count_en = 0; then key_valid with key 4 → IDLE, digits 0, count 0, done = 0.
- Same cycle start + clear in ENTRY → IDLE, digits 0, no entry_err. clrn pulsed low during LOAD → load_n = 1 and all outputs at reset values immediately.
